fetch_decode_queue: RTL and testbench

- Decoupling instruction queue between the fetch stage and the decode stage of the pipelined MIPS core.
- Captures each fetched instruction/PC+4 pair into a small circular FIFO and presents the oldest entry to decode, first-word-fall-through.
- Backpressures fetch through F_ready, which drives fetch's PC-enable directly (enable = F_ready; no inversion).
- Drops all queued instructions on a control-flow flush.

---
 rtl/fetch_decode_queue_pkg.sv | 12 +
 rtl/fetch_decode_queue_storage.sv | 26 ++
 rtl/fetch_decode_queue.sv | 86 ++++++++
 tb/tb_fetch_decode_queue.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_queue_pkg.sv
// Shared constants and entry layout for the fetch/decode instruction queue.
package fetch_decode_queue_pkg;

  localparam int QUEUE_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000000;

  typedef struct packed {
    logic [QUEUE_WIDTH-1:0] instr;
    logic [QUEUE_WIDTH-1:0] pcplus4;
  } queue_entry_t;

endpackage

// File: rtl/fetch_decode_queue_storage.sv
// Queue entry array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the controller.
module fetch_decode_queue_storage #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Combinational read gives first-word-fall-through at the queue head.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Circular instruction queue decoupling fetch from decode; head is presented
// first-word-fall-through and the whole queue is dropped on a redirect.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     F_valid_F,
  input  logic [WIDTH-1:0]         F_instr_F,
  input  logic [WIDTH-1:0]         F_PCPlus4_F,
  output logic                     F_ready,
  input  logic                     D_ready_D,
  input  logic                     flush_D,
  output logic                     D_valid_D,
  output logic [WIDTH-1:0]         D_instr_D,
  output logic [WIDTH-1:0]         D_PCPlus4_D,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("fetch_decode_queue: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               enq;
  logic               deq;
  logic [2*WIDTH-1:0] wr_data;
  logic [2*WIDTH-1:0] rd_data;

  // Readiness comes from registered occupancy only, so a full queue stays
  // closed even while decode is draining it this cycle.
  assign F_ready   = (count_reg != FULL_COUNT);
  assign D_valid_D = (count_reg != '0);
  assign enq       = F_valid_F & F_ready & ~flush_D;
  assign deq       = D_ready_D & D_valid_D & ~flush_D;
  assign wr_data   = {F_instr_F, F_PCPlus4_F};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush_D) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (enq) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (deq) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (enq && !deq) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (deq && !enq) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

  fetch_decode_queue_storage #(
    .DEPTH  (DEPTH),
    .DATA_W (2*WIDTH)
  ) u_storage (
    .clk     (clk),
    .wr_en   (enq),
    .wr_addr (wr_ptr_reg),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_data)
  );

  // An empty head reads as a NOP so decode never sees stale storage.
  assign D_instr_D   = D_valid_D ? rd_data[2*WIDTH-1:WIDTH] : WIDTH'(NOP_INSTR);
  assign D_PCPlus4_D = D_valid_D ? rd_data[WIDTH-1:0]       : '0;
  assign count       = count_reg;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Randomised and directed bench for fetch_decode_queue against a queue model.
module tb_fetch_decode_queue;
  import fetch_decode_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        F_valid_F = 1'b0;
  logic [31:0] F_instr_F = '0;
  logic [31:0] F_PCPlus4_F = '0;
  logic        F_ready;
  logic        D_ready_D = 1'b0;
  logic        flush_D = 1'b0;
  logic        D_valid_D;
  logic [31:0] D_instr_D;
  logic [31:0] D_PCPlus4_D;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  queue_entry_t model_q[$];

  fetch_decode_queue #(.DEPTH(DEPTH), .WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .F_valid_F   (F_valid_F),
    .F_instr_F   (F_instr_F),
    .F_PCPlus4_F (F_PCPlus4_F),
    .F_ready     (F_ready),
    .D_ready_D   (D_ready_D),
    .flush_D     (flush_D),
    .D_valid_D   (D_valid_D),
    .D_instr_D   (D_instr_D),
    .D_PCPlus4_D (D_PCPlus4_D),
    .count       (count)
  );

  always #5 clk = ~clk;

  // Expected {count, F_ready, D_valid_D, D_instr_D, D_PCPlus4_D} from the model.
  function automatic logic [68:0] model_out();
    int n;
    n = model_q.size();
    if (n == 0) return {3'd0, 1'b1, 1'b0, 32'd0, 32'd0};
    return {3'(n), (n != DEPTH), 1'b1, model_q[0].instr, model_q[0].pcplus4};
  endfunction

  function automatic logic [68:0] dut_out();
    return {count, F_ready, D_valid_D, D_instr_D, D_PCPlus4_D};
  endfunction

  // One clock edge; the model applies the queue rules to the pre-edge state.
  task automatic tick();
    bit e, d;
    queue_entry_t ent;
    e = F_valid_F && (model_q.size() < DEPTH) && !flush_D;
    d = D_ready_D && (model_q.size() > 0) && !flush_D;
    ent.instr = F_instr_F;
    ent.pcplus4 = F_PCPlus4_F;
    @(posedge clk);
    if (flush_D) begin
      model_q.delete();
    end else begin
      if (d) void'(model_q.pop_front());
      if (e) model_q.push_back(ent);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (dut_out() !== {3'd0, 1'b1, 1'b0, 64'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", dut_out(), {3'd0, 1'b1, 1'b0, 64'd0});
    end
    reset = 1'b1;
    F_valid_F = 1'b0;
    D_ready_D = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (dut_out() !== model_out()) begin
      n_fail++;
      $display("FAIL reset_idle: got %h expected %h", dut_out(), model_out());
    end
  endtask

  task automatic test_fill();
    D_ready_D = 1'b0;
    F_valid_F = 1'b1;
    for (int i = 0; i < 5; i++) begin
      F_instr_F   = 32'h20080001 + 32'(i);
      F_PCPlus4_F = 32'(4 * (i + 1));
      tick();
      n_checks++;
      if (dut_out() !== model_out()) begin
        n_fail++;
        $display("FAIL fill_%0d: got %h expected %h", i, dut_out(), model_out());
      end
    end
    n_checks++;
    if (count !== 3'd4 || F_ready !== 1'b0 || D_instr_D !== 32'h20080001 || D_PCPlus4_D !== 32'h4) begin
      n_fail++;
      $display("FAIL fill_full: count %0d ready %b head %h/%h, expected 4 0 20080001/00000004",
               count, F_ready, D_instr_D, D_PCPlus4_D);
    end
  endtask

  task automatic test_full_simultaneous();
    F_valid_F = 1'b1;
    F_instr_F = 32'h20080006;
    F_PCPlus4_F = 32'h18;
    D_ready_D = 1'b1;
    n_checks++;
    if (F_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_no_credit: F_ready %b expected 0", F_ready);
    end
    tick();
    n_checks++;
    if (count !== 3'd3 || D_instr_D !== 32'h20080002 || F_ready !== 1'b1 || dut_out() !== model_out()) begin
      n_fail++;
      $display("FAIL full_dequeue_only: got %h expected %h", dut_out(), model_out());
    end
  endtask

  task automatic test_flush();
    F_valid_F = 1'b1;
    F_instr_F = 32'hDEADBEEF;
    F_PCPlus4_F = 32'h100;
    D_ready_D = 1'b1;
    flush_D = 1'b1;
    tick();
    flush_D = 1'b0;
    n_checks++;
    if (dut_out() !== {3'd0, 1'b1, 1'b0, 64'd0}) begin
      n_fail++;
      $display("FAIL flush: got %h expected %h", dut_out(), {3'd0, 1'b1, 1'b0, 64'd0});
    end
    F_valid_F = 1'b0;
    tick();
    n_checks++;
    if (count !== 3'd0 || D_valid_D !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_not_stored: count %0d valid %b expected 0 0", count, D_valid_D);
    end
  endtask

  task automatic test_stream();
    int seen;
    seen = 0;
    F_valid_F = 1'b1;
    D_ready_D = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i == 10) F_valid_F = 1'b0;
      F_instr_F   = 32'h24000000 + 32'(i);
      F_PCPlus4_F = 32'h400 + 32'(4 * i);
      if (D_valid_D === 1'b1) begin
        n_checks++;
        if (D_instr_D !== 32'h24000000 + 32'(seen) || D_PCPlus4_D !== 32'h400 + 32'(4 * seen)) begin
          n_fail++;
          $display("FAIL stream_order_%0d: got %h/%h expected %h/%h", seen, D_instr_D, D_PCPlus4_D,
                   32'h24000000 + 32'(seen), 32'h400 + 32'(4 * seen));
        end
        seen++;
      end
      tick();
      n_checks++;
      if (dut_out() !== model_out() || (i < 10 && count !== 3'd1)) begin
        n_fail++;
        $display("FAIL stream_cycle_%0d: got %h expected %h", i, dut_out(), model_out());
      end
    end
    n_checks++;
    if (seen !== 10) begin
      n_fail++;
      $display("FAIL stream_total: saw %0d expected 10", seen);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      F_valid_F   = ($urandom_range(0, 3) != 0);
      D_ready_D   = ($urandom_range(0, 2) != 0);
      flush_D     = ($urandom_range(0, 19) == 0);
      F_instr_F   = $urandom;
      F_PCPlus4_F = $urandom;
      tick();
      n_checks++;
      if (dut_out() !== model_out()) begin
        n_fail++;
        $display("FAIL random_%0d: got %h expected %h", i, dut_out(), model_out());
      end
    end
    flush_D = 1'b0;
  endtask

  task automatic test_async_reset();
    flush_D = 1'b1;
    tick();
    flush_D = 1'b0;
    D_ready_D = 1'b0;
    F_valid_F = 1'b1;
    for (int i = 0; i < 2; i++) begin
      F_instr_F = 32'h3C010000 + 32'(i);
      F_PCPlus4_F = 32'h800 + 32'(4 * i);
      tick();
    end
    F_valid_F = 1'b0;
    n_checks++;
    if (count !== 3'd2) begin
      n_fail++;
      $display("FAIL async_setup: count %0d expected 2", count);
    end
    #2 reset = 1'b0;
    #1;
    model_q.delete();
    n_checks++;
    if (dut_out() !== {3'd0, 1'b1, 1'b0, 64'd0}) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", dut_out(), {3'd0, 1'b1, 1'b0, 64'd0});
    end
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    n_checks++;
    if (dut_out() !== model_out()) begin
      n_fail++;
      $display("FAIL async_release: got %h expected %h", dut_out(), model_out());
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_simultaneous();
    test_flush();
    test_stream();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
